// File: rtl/la_bec_mbox.sv
`default_nettype none
// ============================================================================
//  Module   : la_bec_mbox
//  Purpose  : Logic-analyser mailbox between the management core and the BEC
//             point-multiplication core. Operands are loaded word by word,
//             single or chained runs are started, and results are read back.
//             A 16-bit status code is driven out for the checkbits.
//  Revision : 1.0 - initial release
// ============================================================================
module la_bec_mbox #(
   parameter int LA_W      = 32,
   parameter int OP_W      = 163,
   parameter int NUM_OPS   = 4,
   parameter int NUM_RES   = 2,
   parameter int CHAIN_IDX = 1,
   parameter int TIMEOUT   = 2**20
) (
   input  logic                    clock,
   input  logic                    resetb,
   input  logic                    la_req_tgl,
   input  logic [1:0]              la_cmd,
   input  logic [7:0]              la_sel,
   input  logic [LA_W-1:0]         la_data_in,
   output logic                    la_ack_tgl,
   output logic [LA_W-1:0]         la_data_out,
   output logic                    core_start,
   output logic [NUM_OPS*OP_W-1:0] core_op,
   input  logic                    core_done,
   input  logic [NUM_RES*OP_W-1:0] core_res,
   output logic [15:0]             status,
   output logic                    busy
);

   // Words per operand; the last word only carries the low leftover bits.
   localparam int WPO   = (OP_W + LA_W - 1) / LA_W;
   localparam int OPI_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int RSI_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
   localparam int BIT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
   localparam int DIN_W = (LA_W > 1) ? $clog2(LA_W) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   localparam logic [1:0] CMD_WRITE = 2'd0;
   localparam logic [1:0] CMD_START = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [15:0]     status_nxt;
   logic            req_d1;
   logic            cmd_fire;
   logic            is_clear;
   logic [3:0]      sel_hi;
   logic [3:0]      sel_lo;
   logic            wr_ok;
   logic            rd_ok;
   logic [OPI_W-1:0] op_idx;
   logic [RSI_W-1:0] res_idx;
   logic [OP_W-1:0] ops [NUM_OPS];
   logic [OP_W-1:0] res [NUM_RES];
   logic [OP_W-1:0] wr_val;
   logic [LA_W-1:0] rd_val;
   logic [7:0]      iter_left;
   logic [TO_W-1:0] tcnt;

   // A command is pending whenever the registered request parity differs from ack.
   assign cmd_fire = req_d1 ^ la_ack_tgl;
   assign is_clear = cmd_fire && (la_cmd == 2'd3);
   assign sel_hi   = la_sel[7:4];
   assign sel_lo   = la_sel[3:0];
   assign wr_ok    = ({1'b0, sel_hi} < 5'(NUM_OPS)) && ({1'b0, sel_lo} < 5'(WPO));
   assign rd_ok    = ({1'b0, sel_hi} < 5'(NUM_RES)) && ({1'b0, sel_lo} < 5'(WPO));
   assign op_idx   = sel_hi[OPI_W-1:0];
   assign res_idx  = sel_hi[RSI_W-1:0];

   // Merge the incoming word into the addressed operand; bits past OP_W fall away.
   always_comb begin
      wr_val = ops[op_idx];
      for (int b = 0; b < OP_W; b++) begin
         if ((b / LA_W) == int'(sel_lo)) begin
            wr_val[BIT_W'(b)] = la_data_in[DIN_W'(b % LA_W)];
         end
      end
   end

   // Extract the addressed result word, zero-extended; out-of-range reads give 0.
   always_comb begin
      rd_val = '0;
      if (rd_ok) begin
         for (int b = 0; b < LA_W; b++) begin
            if ((int'(sel_lo) * LA_W + b) < OP_W) begin
               rd_val[DIN_W'(b)] = res[res_idx][BIT_W'(int'(sel_lo) * LA_W + b)];
            end
         end
      end
   end

   // State and status registers; status tracks the state being entered.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         state  <= S_IDLE;
         status <= 16'hAB30;
      end else begin
         state  <= state_nxt;
         status <= status_nxt;
      end
   end

   // Next-state selection; CLEAR overrides everything including a same-cycle done.
   always_comb begin
      state_nxt = state;
      if (is_clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_RUN:   state_nxt = S_WAIT;
            S_WAIT: begin
               if (core_done) begin
                  state_nxt = (iter_left > 8'd1) ? S_RUN : S_DONE;
               end else if (tcnt == TO_LAST) begin
                  state_nxt = S_ERR;
               end
            end
            default: begin
               if (cmd_fire && (la_cmd == CMD_WRITE)) begin
                  state_nxt = wr_ok ? S_LOAD : S_ERR;
               end else if (cmd_fire && (la_cmd == CMD_START)) begin
                  state_nxt = S_RUN;
               end
            end
         endcase
      end
   end

   // Moore outputs plus the status code for the upcoming state.
   always_comb begin
      busy       = (state == S_RUN) || (state == S_WAIT);
      core_start = (state == S_RUN);
      case (state_nxt)
         S_LOAD:         status_nxt = 16'hAB41;
         S_RUN, S_WAIT:  status_nxt = 16'hAB42;
         S_DONE:         status_nxt = 16'hAB51;
         S_ERR:          status_nxt = 16'hAB44;
         default:        status_nxt = 16'hAB30;
      endcase
   end

   // Handshake, operand/result storage, iteration and timeout bookkeeping.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         req_d1      <= 1'b0;
         la_ack_tgl  <= 1'b0;
         la_data_out <= '0;
         iter_left   <= '0;
         tcnt        <= '0;
         for (int i = 0; i < NUM_OPS; i++) ops[i] <= '0;
         for (int r = 0; r < NUM_RES; r++) res[r] <= '0;
      end else begin
         req_d1 <= la_req_tgl;
         if (cmd_fire) begin
            la_ack_tgl <= ~la_ack_tgl;
            case (la_cmd)
               CMD_WRITE: if (!busy && wr_ok) ops[op_idx] <= wr_val;
               CMD_START: if (!busy) iter_left <= (la_data_in[8] && (la_data_in[7:0] > 8'd1))
                                                  ? la_data_in[7:0] : 8'd1;
               CMD_READ:  la_data_out <= rd_val;
               default: begin
                  for (int r = 0; r < NUM_RES; r++) res[r] <= '0;
                  iter_left <= '0;
               end
            endcase
         end
         if (state == S_RUN) begin
            tcnt <= '0;
         end else if ((state == S_WAIT) && !is_clear) begin
            tcnt <= tcnt + TO_W'(1);
            if (core_done) begin
               for (int r = 0; r < NUM_RES; r++) res[r] <= core_res[r*OP_W +: OP_W];
               iter_left <= iter_left - 8'd1;
               // Feed result 0 back into the chained operand for the next run.
               if (iter_left > 8'd1) ops[CHAIN_IDX] <= core_res[OP_W-1:0];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
      assign core_op[i*OP_W +: OP_W] = ops[i];
   end

endmodule
`default_nettype wire
